regfile_wb_ctrl: RTL

//  Write-back initiator for the 32x32 register file: the block that drives the regfile write

---
 rtl/regfile_wb_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/regfile_wb_ctrl.sv
// Write-back initiator for the 32x32 register file: queues ALU/load write-back requests,
// issues at most one regfile write per clock and forwards pending values for rs/rt.
module regfile_wb_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alu_valid,
    input  logic [AW-1:0]          alu_rd,
    input  logic [DW-1:0]          alu_data,
    output logic                   alu_ready,
    input  logic                   mem_valid,
    input  logic [AW-1:0]          mem_rd,
    input  logic [DW-1:0]          mem_data,
    output logic                   mem_ready,
    input  logic                   wb_stall,
    output logic                   RegWr,
    output logic [AW-1:0]          rd,
    output logic [DW-1:0]          busW,
    input  logic [AW-1:0]          rs,
    input  logic [AW-1:0]          rt,
    output logic                   fwd_a_hit,
    output logic [DW-1:0]          fwd_a_data,
    output logic                   fwd_b_hit,
    output logic [DW-1:0]          fwd_b_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0] r_mem_rd   [DEPTH];
    logic [DW-1:0] r_mem_data [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_regwr;
    logic [AW-1:0] r_rd;
    logic [DW-1:0] r_busw;

    logic          w_acc;
    logic [AW-1:0] w_acc_rd;
    logic [DW-1:0] w_acc_data;
    logic          w_push;
    logic          w_pop;

    // Ready comes from registered occupancy only, so a popping full FIFO still refuses.
    assign mem_ready = (r_count < FULL);
    assign alu_ready = (r_count < FULL) && !mem_valid;
    assign RegWr     = r_regwr;
    assign rd        = r_rd;
    assign busW      = r_busw;
    assign count     = r_count;

    // Select the accepted request; the load unit wins over the ALU.
    always_comb begin
        w_acc      = 1'b0;
        w_acc_rd   = '0;
        w_acc_data = '0;
        if (mem_valid && mem_ready) begin
            w_acc      = 1'b1;
            w_acc_rd   = mem_rd;
            w_acc_data = mem_data;
        end else if (alu_valid && alu_ready) begin
            w_acc      = 1'b1;
            w_acc_rd   = alu_rd;
            w_acc_data = alu_data;
        end else begin
            w_acc      = 1'b0;
        end
    end

    // Writes to $0 complete the handshake but are dropped here.
    assign w_push = w_acc && (w_acc_rd != '0);
    assign w_pop  = !wb_stall && (r_count != '0);

    // FIFO storage, pointers, occupancy and the registered issue stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_rd[i]   <= '0;
                r_mem_data[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_regwr <= 1'b0;
            r_rd    <= '0;
            r_busw  <= '0;
        end else begin
            if (w_push) begin
                r_mem_rd[r_wptr]   <= w_acc_rd;
                r_mem_data[r_wptr] <= w_acc_data;
                r_wptr             <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_regwr <= 1'b1;
                r_rd    <= r_mem_rd[r_rptr];
                r_busw  <= r_mem_data[r_rptr];
                r_rptr  <= r_rptr + PW'(1);
            end else begin
                r_regwr <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Forwarding: issue stage first, then FIFO oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_a_hit  = 1'b0;
        fwd_a_data = '0;
        fwd_b_hit  = 1'b0;
        fwd_b_data = '0;
        if (r_regwr && (r_rd == rs) && (rs != '0)) begin
            fwd_a_hit  = 1'b1;
            fwd_a_data = r_busw;
        end else begin
            fwd_a_hit  = 1'b0;
        end
        if (r_regwr && (r_rd == rt) && (rt != '0)) begin
            fwd_b_hit  = 1'b1;
            fwd_b_data = r_busw;
        end else begin
            fwd_b_hit  = 1'b0;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < r_count) && (r_mem_rd[r_rptr + PW'(k)] == rs) && (rs != '0)) begin
                fwd_a_hit  = 1'b1;
                fwd_a_data = r_mem_data[r_rptr + PW'(k)];
            end else begin
                fwd_a_hit  = fwd_a_hit;
            end
            if ((CW'(k) < r_count) && (r_mem_rd[r_rptr + PW'(k)] == rt) && (rt != '0)) begin
                fwd_b_hit  = 1'b1;
                fwd_b_data = r_mem_data[r_rptr + PW'(k)];
            end else begin
                fwd_b_hit  = fwd_b_hit;
            end
        end
    end

endmodule
